// File: rtl/io_cfg_pkg.sv
// io_cfg_pkg: register map, status bit positions and FSM states for the I/O cell config controller
package io_cfg_pkg;
  localparam logic [7:0] SHADOW_BASE = 8'h00;
  localparam logic [7:0] ACTIVE_BASE = 8'h40;
  localparam logic [7:0] COMMIT_OFS  = 8'h80;
  localparam logic [7:0] STATUS_OFS  = 8'h84;
  localparam int STAT_BUSY = 0;
  localparam int STAT_PEND = 1;
  typedef enum logic {IDLE, APPLY} cfg_state_e;
endpackage

// File: rtl/io_cfg_apb_if.sv
// io_cfg_apb_if: APB decode, ready/error generation, shadow-write stall and read mux
module io_cfg_apb_if
  import io_cfg_pkg::*;
#(
  parameter int CONF_WIDTH = 5,
  parameter int NUM_CELLS  = 10
) (
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [7:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  busy,
  input  logic                  pending,
  input  logic [CONF_WIDTH-1:0] shadow_rd,
  input  logic [CONF_WIDTH-1:0] active_rd,
  output logic [3:0]            reg_idx,
  output logic [CONF_WIDTH-1:0] wdata,
  output logic                  shadow_we,
  output logic                  commit_we
);
  logic access, in_range, sh_hit, ac_hit, cm_hit, st_hit, ok, stall, unused_bits;
  logic [31:0] status, rd_word;
  assign access   = psel & penable;
  assign reg_idx  = paddr[5:2];
  assign wdata    = pwdata[CONF_WIDTH-1:0];
  assign in_range = {1'b0, reg_idx} < 5'(NUM_CELLS);
  assign sh_hit   = paddr[7:6] == SHADOW_BASE[7:6] && in_range;
  assign ac_hit   = paddr[7:6] == ACTIVE_BASE[7:6] && in_range && !pwrite;
  assign cm_hit   = paddr[7:2] == COMMIT_OFS[7:2];
  assign st_hit   = paddr[7:2] == STATUS_OFS[7:2] && !pwrite;
  assign ok       = sh_hit | ac_hit | cm_hit | st_hit;
  // shadow writes wait out an in-flight commit so active never copies a half-updated shadow
  assign stall     = sh_hit & pwrite & busy;
  assign pready    = access & !stall;
  assign pslverr   = access & !ok;
  assign shadow_we = pready & sh_hit & pwrite;
  assign commit_we = pready & cm_hit & pwrite & pwdata[0];
  assign status    = (32'(busy) << STAT_BUSY) | (32'(pending) << STAT_PEND);
  assign rd_word   = sh_hit ? 32'(shadow_rd) : ac_hit ? 32'(active_rd) : st_hit ? status : '0;
  assign prdata    = (pready & !pwrite) ? rd_word : '0;
  assign unused_bits = ^{pwdata[31:CONF_WIDTH], paddr[1:0]};
endmodule

// File: rtl/io_cell_cfg_ctrl.sv
// io_cell_cfg_ctrl: shadow/active I/O cell config registers with a staggered one-cell-at-a-time commit
module io_cell_cfg_ctrl
  import io_cfg_pkg::*;
#(
  parameter int CONF_WIDTH = 5,
  parameter int NUM_CELLS  = 10,
  parameter int STAGGER    = 2,
  parameter logic [NUM_CELLS*CONF_WIDTH-1:0] RESET_CFG = '0
) (
  input  logic                            clk_internal,
  input  logic                            reset_internal,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [7:0]                      paddr,
  input  logic [31:0]                     pwdata,
  output logic [31:0]                     prdata,
  output logic                            pready,
  output logic                            pslverr,
  output logic [NUM_CELLS*CONF_WIDTH-1:0] cell_cfg,
  output logic                            cfg_busy,
  output logic                            cfg_done
);
  localparam int GW = $clog2(STAGGER + 1);
  typedef logic [CONF_WIDTH-1:0] cell_t;
  cfg_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d, reg_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic recommit_q, recommit_d, done_q, done_d;
  cell_t shadow_q [NUM_CELLS];
  cell_t shadow_d [NUM_CELLS];
  cell_t active_q [NUM_CELLS];
  cell_t active_d [NUM_CELLS];
  cell_t wdata, shadow_rd, active_rd;
  logic shadow_we, commit_we, in_range, pending;
  logic [NUM_CELLS*CONF_WIDTH-1:0] shadow_flat;

  io_cfg_apb_if #(.CONF_WIDTH(CONF_WIDTH), .NUM_CELLS(NUM_CELLS)) u_apb (
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(cfg_busy), .pending(pending), .shadow_rd(shadow_rd), .active_rd(active_rd),
    .reg_idx(reg_idx), .wdata(wdata), .shadow_we(shadow_we), .commit_we(commit_we)
  );

  assign in_range  = {1'b0, reg_idx} < 5'(NUM_CELLS);
  assign shadow_rd = in_range ? shadow_q[reg_idx] : '0;
  assign active_rd = in_range ? active_q[reg_idx] : '0;
  assign cfg_busy  = state_q == APPLY;
  assign cfg_done  = done_q;
  assign pending   = shadow_flat != cell_cfg;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_flat
    assign cell_cfg[i*CONF_WIDTH +: CONF_WIDTH]    = active_q[i];
    assign shadow_flat[i*CONF_WIDTH +: CONF_WIDTH] = shadow_q[i];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    recommit_d = recommit_q;
    done_d     = 1'b0;
    shadow_d   = shadow_q;
    active_d   = active_q;
    if (shadow_we) shadow_d[reg_idx] = wdata;
    if (state_q == IDLE) begin
      if (commit_we) begin
        state_d = APPLY;
        idx_d   = '0;
        gap_d   = '0;
      end
    end else begin
      recommit_d = recommit_q | commit_we;
      if (gap_q != '0) gap_d = gap_q - 1'b1;
      else begin
        active_d[idx_q] = shadow_q[idx_q];
        gap_d = GW'(STAGGER - 1);
        if (idx_q == 4'(NUM_CELLS - 1)) begin
          // a commit that arrived during this pass replays the whole frame instead of finishing
          idx_d      = '0;
          recommit_d = 1'b0;
          state_d    = (recommit_q | commit_we) ? APPLY : IDLE;
          done_d     = !(recommit_q | commit_we);
        end else idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_internal) begin
    if (!reset_internal) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      recommit_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        shadow_q[i] <= RESET_CFG[i*CONF_WIDTH +: CONF_WIDTH];
        active_q[i] <= RESET_CFG[i*CONF_WIDTH +: CONF_WIDTH];
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      recommit_q <= recommit_d;
      done_q     <= done_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end
endmodule

// File: tb/tb_io_cell_cfg_ctrl.sv
// tb_io_cell_cfg_ctrl: directed and random APB traffic checked every cycle against a commit-schedule model
module tb_io_cell_cfg_ctrl;
  localparam int N = 10;
  localparam int W = 5;
  localparam int S = 2;

  logic clk_internal = 0, reset_internal = 0, psel = 0, penable = 0, pwrite = 0;
  logic [7:0] paddr = 0;
  logic [31:0] pwdata = 0, prdata;
  logic pready, pslverr, cfg_busy, cfg_done;
  logic [N*W-1:0] cell_cfg;
  int cyc = 0, n_checks = 0, n_fail = 0, n_done = 0, last_done = -1;

  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_ac [N];
  logic m_busy = 0, m_rc = 0, m_done = 0;
  int m_p = 0;

  io_cell_cfg_ctrl #(.CONF_WIDTH(W), .NUM_CELLS(N), .STAGGER(S), .RESET_CFG('0)) dut (
    .clk_internal(clk_internal), .reset_internal(reset_internal),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cell_cfg(cell_cfg), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk_internal = ~clk_internal;
  always @(posedge clk_internal) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: a commit accepted in cycle c makes cell i visible at c+2+i*S; a pass ends when the last cell lands
  always @(negedge clk_internal) begin : cmp
    int a;
    logic acc, is_sh, is_ac, is_cm, is_st, ok, e_rdy, e_err, pend;
    logic [31:0] e_rd;
    logic [N*W-1:0] e_cfg;
    a     = int'(paddr) & 'hFC;
    acc   = psel && penable;
    is_sh = a < 4*N;
    is_ac = a >= 64 && a < 64 + 4*N;
    is_cm = a == 128;
    is_st = a == 132;
    ok    = is_sh || (is_ac && !pwrite) || is_cm || (is_st && !pwrite);
    e_rdy = acc && !(is_sh && pwrite && m_busy);
    e_err = acc && !ok;
    pend  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_sh[i] != m_ac[i]) pend = 1;
      e_cfg[i*W +: W] = m_ac[i];
    end
    e_rd = 0;
    if (e_rdy && !pwrite && ok) begin
      if (is_sh) e_rd = 32'(m_sh[a/4]);
      else if (is_ac) e_rd = 32'(m_ac[(a-64)/4]);
      else if (is_st) e_rd = 32'({pend, m_busy});
    end
    if (cyc >= 1) begin
      chk("pready", 64'(pready), 64'(e_rdy));
      chk("pslverr", 64'(pslverr), 64'(e_err));
      chk("prdata", 64'(prdata), 64'(e_rd));
      chk("cell_cfg", 64'(cell_cfg), 64'(e_cfg));
      chk("cfg_busy", 64'(cfg_busy), 64'(m_busy));
      chk("cfg_done", 64'(cfg_done), 64'(m_done));
      if (cfg_done === 1'b1) begin
        n_done++;
        last_done = cyc;
      end
    end
    if (!reset_internal) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = 0;
        m_ac[i] = 0;
      end
      m_busy = 0; m_rc = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (e_rdy && is_sh && pwrite) m_sh[a/4] = pwdata[W-1:0];
      if (e_rdy && is_cm && pwrite && pwdata[0]) begin
        if (m_busy) m_rc = 1;
        else begin
          m_busy = 1;
          m_p = cyc + 2;
        end
      end
      if (m_busy) begin
        for (int i = 0; i < N; i++) if (cyc + 1 == m_p + i*S) m_ac[i] = m_sh[i];
        if (cyc + 1 == m_p + (N-1)*S) begin
          if (m_rc) begin
            m_rc = 0;
            m_p = m_p + N*S;
          end else begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int t);
    logic got;
    got = 0;
    @(posedge clk_internal); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk_internal); #1;
    penable = 1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk_internal);
      got = pready;
    end
    rd = prdata; err = pslverr; t = cyc;
    chk("apb_handshake", 64'(got), 64'(1));
    @(posedge clk_internal); #1;
    psel = 0; penable = 0;
  endtask

  task automatic wait_until(input int n);
    while (1) begin
      @(negedge clk_internal);
      if (cyc >= n) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int t, t2, d0;
    for (int i = 0; i < N; i++) begin
      m_sh[i] = 0;
      m_ac[i] = 0;
    end
    repeat (3) @(posedge clk_internal);
    #1 reset_internal = 1;
    wait_until(4);
    chk("rst_cell_cfg", 64'(cell_cfg), 64'(0));
    chk("rst_busy", 64'(cfg_busy), 64'(0));
    chk("rst_done", 64'(cfg_done), 64'(0));
    chk("rst_pready", 64'(pready), 64'(0));
    chk("rst_prdata", 64'(prdata), 64'(0));
    apb(0, 8'h84, 0, rd, er, t);
    chk("rst_status", 64'(rd), 64'(0));

    apb(1, 8'h0C, 32'h1A, rd, er, t);
    apb(1, 8'h80, 32'h1, rd, er, t);
    wait_until(t + 1);
    chk("busy_t1", 64'(cfg_busy), 64'(1));
    wait_until(t + 7);
    chk("cell3_t7", 64'(cell_cfg[19:15]), 64'(0));
    wait_until(t + 8);
    chk("cell3_t8", 64'(cell_cfg[19:15]), 64'(5'h1A));
    wait_until(t + 19);
    chk("done_t19", 64'(cfg_done), 64'(0));
    wait_until(t + 20);
    chk("done_t20", 64'(cfg_done), 64'(1));
    chk("busy_t20", 64'(cfg_busy), 64'(0));
    apb(0, 8'h4C, 0, rd, er, t2);
    chk("active3_rd", 64'(rd), 64'(5'h1A));
    apb(0, 8'h84, 0, rd, er, t2);
    chk("status_after", 64'(rd), 64'(0));

    apb(1, 8'h80, 32'h1, rd, er, t);
    apb(1, 8'h00, 32'h15, rd, er, t2);
    chk("stall_release_cycle", 64'(t2), 64'(t + 20));
    apb(0, 8'h40, 0, rd, er, t2);
    chk("active0_unchanged", 64'(rd), 64'(0));
    apb(0, 8'h84, 0, rd, er, t2);
    chk("status_pending", 64'(rd), 64'(2));

    d0 = n_done;
    apb(1, 8'h80, 32'h1, rd, er, t);
    apb(1, 8'h80, 32'h1, rd, er, t2);
    wait_until(t + 20);
    chk("rc_busy_t20", 64'(cfg_busy), 64'(1));
    chk("rc_done_t20", 64'(cfg_done), 64'(0));
    wait_until(t + 39);
    chk("rc_busy_t39", 64'(cfg_busy), 64'(1));
    wait_until(t + 45);
    chk("rc_done_count", 64'(n_done - d0), 64'(1));
    chk("rc_done_cycle", 64'(last_done), 64'(t + 40));

    apb(0, 8'h28, 0, rd, er, t2);
    chk("err_rd28", 64'({er, rd}), 64'({1'b1, 32'h0}));
    apb(1, 8'h28, 32'h1F, rd, er, t2);
    chk("err_wr28", 64'(er), 64'(1));
    apb(1, 8'h84, 32'h3, rd, er, t2);
    chk("err_wr84", 64'(er), 64'(1));
    apb(0, 8'hF0, 0, rd, er, t2);
    chk("err_rdF0", 64'({er, rd}), 64'({1'b1, 32'h0}));
    apb(1, 8'h44, 32'h7, rd, er, t2);
    chk("err_wr_active", 64'(er), 64'(1));
    apb(0, 8'h84, 0, rd, er, t2);
    chk("err_no_effect", 64'({er, rd}), 64'(0));

    for (int i = 0; i < N; i++) apb(1, 8'(4*i), 32'(i + 1), rd, er, t2);
    apb(1, 8'h80, 32'h1, rd, er, t);
    wait_until(t + 7);
    @(posedge clk_internal); #1;
    reset_internal = 0;
    wait_until(t + 8);
    chk("pre_reset_cells", 64'(cell_cfg[19:0]), 64'({5'd4, 5'd3, 5'd2, 5'd1}));
    wait_until(t + 9);
    chk("midreset_cell_cfg", 64'(cell_cfg), 64'(0));
    chk("midreset_busy", 64'(cfg_busy), 64'(0));
    @(posedge clk_internal); #1;
    reset_internal = 1;
    apb(0, 8'h08, 0, rd, er, t2);
    chk("shadow2_reset", 64'(rd), 64'(0));
    apb(0, 8'h24, 0, rd, er, t2);
    chk("shadow9_reset", 64'(rd), 64'(0));

    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) apb(1, 8'(4 * $urandom_range(0, 11)), $urandom, rd, er, t2);
      else if (r <= 5) apb(0, 8'($urandom_range(0, 255)), 0, rd, er, t2);
      else if (r == 6) apb(1, 8'h80, $urandom, rd, er, t2);
      else if (r == 7) apb(0, 8'h84, 0, rd, er, t2);
      else if (r == 8) apb(1, 8'($urandom_range(0, 255)), $urandom, rd, er, t2);
      else repeat ($urandom_range(1, 6)) @(posedge clk_internal);
    end
    for (int k = 0; k < 100 && m_busy; k++) @(negedge clk_internal);
    chk("drain_idle", 64'(m_busy), 64'(0));
    @(negedge clk_internal);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
